// File: rtl/config_pkg.sv
// config_pkg: shared types and defaults for the LED blink arbiter
//   led_arb_state_e    - arbiter FSM states (IDLE, SHOW, GAP)
//   DefaultPeriodWidth - default width of a requester half-period code
package config_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} led_arb_state_e;
    localparam int unsigned DefaultPeriodWidth = 4;
endpackage

// File: rtl/bsg_counter_up_down.sv
// bsg_counter_up_down: up/down counter with synchronous reset to init_val_p
//   clk_i   - clock
//   reset_i - synchronous reset, loads init_val_p
//   up_i    - amount added this cycle
//   down_i  - amount subtracted this cycle
//   count_o - current count
module bsg_counter_up_down #(
    parameter  int unsigned max_val_p  = 1,
    parameter  int unsigned init_val_p = 0,
    parameter  int unsigned max_step_p = 1,
    localparam int unsigned StepW      = $clog2(max_step_p + 1),
    localparam int unsigned CntW       = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [StepW-1:0] up_i,
    input  logic [StepW-1:0] down_i,
    output logic [CntW-1:0]  count_o
);
    logic [CntW-1:0] count_q;
    always_ff @(posedge clk_i)
        count_q <= reset_i ? CntW'(init_val_p) : count_q - CntW'(down_i) + CntW'(up_i);
    assign count_o = count_q;
endmodule

// File: rtl/led_arb_rr_pick.sv
// led_arb_rr_pick: combinational next-winner search over the request vector
//   ptr_i - index of the previous winner; search starts one above it (absent in fixed-priority build)
//   req_i - request vector
//   gnt_o - one-hot winner, all zero when nothing is requested
//   idx_o - winner index, zero when nothing is requested
//   LED_ARB_FIXED_PRIO_EN defined: plain priority encoder, lowest index wins
module led_arb_rr_pick
    import config_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
`ifndef LED_ARB_FIXED_PRIO_EN
    input  logic [IdxW-1:0]   ptr_i,
`endif
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);
`ifdef LED_ARB_FIXED_PRIO_EN
    always_comb begin
        idx_o = '0;
        for (int k = NumReq - 1; k >= 0; k--) idx_o = req_i[k] ? IdxW'(k) : idx_o;
    end
`else
    logic [IdxW-1:0] hi_idx, lo_idx;
    logic            hi_any;
    // requesters above the pointer win first; otherwise wrap to the lowest one at or below it
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_i[k] && IdxW'(k) > ptr_i) begin
                hi_idx = IdxW'(k);
                hi_any = 1'b1;
            end
            if (req_i[k] && IdxW'(k) <= ptr_i) lo_idx = IdxW'(k);
        end
        idx_o = hi_any ? hi_idx : lo_idx;
    end
`endif
    assign gnt_o = (|req_i) ? (NumReq'(1) << idx_o) : '0;
endmodule

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: time-shares one status LED between requesters, each blinking at its own rate
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   req_i    - level request per requester
//   period_i - half-period in ticks per requester, 0 = solid on
//   gnt_o    - one-hot current owner, zero when nobody owns the LED
//   led_o    - registered LED drive
//   tick_o   - one-cycle timebase pulse
//   LED_ARB_FIXED_PRIO_EN defined: fixed priority (lowest index wins), no round-robin pointer
module led_blink_arbiter
    import config_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned CyclesPerTick = 1_000_000,
    parameter int unsigned MinHoldTicks  = 8,
    parameter int unsigned PeriodWidth   = DefaultPeriodWidth
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_i,
    input  logic [NumReq-1:0][PeriodWidth-1:0] period_i,
    output logic [NumReq-1:0]                 gnt_o,
    output logic                              led_o,
    output logic                              tick_o
);
    localparam int unsigned IdxW  = $clog2(NumReq);
    localparam int unsigned HoldW = $clog2(MinHoldTicks + 1);
    localparam int unsigned PresW = (CyclesPerTick > 1) ? $clog2(CyclesPerTick) : 1;

    if (NumReq < 2) begin : g_bad_num_req
        $error("led_blink_arbiter: NumReq must be at least 2");
    end
    if (CyclesPerTick < 1) begin : g_bad_cycles
        $error("led_blink_arbiter: CyclesPerTick must be at least 1");
    end
    if (MinHoldTicks < 1) begin : g_bad_hold
        $error("led_blink_arbiter: MinHoldTicks must be at least 1");
    end

    led_arb_state_e         state_q, state_d;
    logic [NumReq-1:0]      gnt_q, gnt_d, pick_gnt;
    logic [IdxW-1:0]        pick_idx;
    logic [PeriodWidth-1:0] period_q, period_d, phase_q, phase_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic                   led_q, led_d;
    logic [PresW-1:0]       pres_cnt;
    logic                   tick, restart, toggle, owner_on, others, hold_done;

    // prescaler restarts on wrap and on every state change so each state starts a fresh tick period
    bsg_counter_up_down #(
        .max_val_p (CyclesPerTick - 1),
        .init_val_p(0),
        .max_step_p(1)
    ) u_pres (
        .clk_i  (clk_i),
        .reset_i(!rst_ni || restart),
        .up_i   (1'b1),
        .down_i (1'b0),
        .count_o(pres_cnt)
    );

    // gating with rst_ni keeps tick_o low during reset before the counter has seen a clock edge
    assign tick    = rst_ni && pres_cnt == PresW'(CyclesPerTick - 1);
    assign restart = tick || state_d != state_q;

`ifndef LED_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0] ptr_q, ptr_d;
    assign ptr_d = (state_q == IDLE && |req_i) ? pick_idx : ptr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= IdxW'(NumReq - 1);
        else         ptr_q <= ptr_d;
    end
`endif

    led_arb_rr_pick #(.NumReq(NumReq)) u_pick (
`ifndef LED_ARB_FIXED_PRIO_EN
        .ptr_i(ptr_q),
`endif
        .req_i(req_i),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx)
    );

    assign owner_on  = |(req_i & gnt_q);
    assign others    = |(req_i & ~gnt_q);
    // hold counts as done on the tick that carries it to saturation, so a SHOW lasts exactly MinHoldTicks ticks
    assign hold_done = hold_q == HoldW'(MinHoldTicks) || (tick && hold_q == HoldW'(MinHoldTicks - 1));
    assign toggle    = tick && period_q != '0 && phase_q == period_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        period_d = period_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        led_d    = 1'b0;
        case (state_q)
            IDLE: if (|req_i) begin
                state_d  = SHOW;
                gnt_d    = pick_gnt;
                period_d = period_i[pick_idx];
                phase_d  = '0;
                hold_d   = '0;
                led_d    = 1'b1;
            end
            SHOW: if (!owner_on || (hold_done && others)) begin
                state_d = GAP;
            end else begin
                led_d   = led_q ^ toggle;
                phase_d = toggle ? '0 : phase_q + PeriodWidth'(tick && period_q != '0);
                hold_d  = hold_q + HoldW'(tick && hold_q != HoldW'(MinHoldTicks));
            end
            GAP:     state_d = tick ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            period_q <= '0;
            phase_q  <= '0;
            hold_q   <= '0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            led_q    <= led_d;
        end
    end

    assign gnt_o  = (state_q == SHOW) ? gnt_q : '0;
    assign led_o  = led_q;
    assign tick_o = tick;
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: scoreboard bench for led_blink_arbiter (4 requesters, 4 cycles/tick, hold 2 ticks)
module tb_led_blink_arbiter;
    localparam int N  = 4;
    localparam int C  = 4;
    localparam int M  = 2;
    localparam int PW = 4;

    typedef struct {
        string        tag;
        logic [N-1:0] gnt;
        logic         led;
        logic         tick;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic [N-1:0][PW-1:0] period;
    logic [N-1:0]         gnt;
    logic                 led, tick;
    exp_t                 sb[$];
    int                   checks = 0;
    int                   errors = 0;
    int                   ptr = N - 1;
    int                   g;

    led_blink_arbiter #(
        .NumReq       (N),
        .CyclesPerTick(C),
        .MinHoldTicks (M),
        .PeriodWidth  (PW)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .period_i(period),
        .gnt_o   (gnt),
        .led_o   (led),
        .tick_o  (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef LED_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int i = 1; i <= N; i++) if (r[(p + i) % N]) return (p + i) % N;
`endif
        return 0;
    endfunction

    task automatic push(input string tag, input logic [N-1:0] ge, input logic le, input logic te);
        exp_t e;
        e.tag  = tag;
        e.gnt  = ge;
        e.led  = le;
        e.tick = te;
        sb.push_back(e);
    endtask

    // SHOW cycles i0..i0+n-1 counted from grant entry: led toggles every p ticks, tick on the last cycle of each tick
    task automatic exp_show(input string tag, input int o, input int p, input int i0, input int n);
        for (int i = i0; i < i0 + n; i++)
            push(tag, N'(1) << o, (p == 0) || ((i / (p * C)) % 2 == 0), i % C == C - 1);
    endtask

    // GAP (C cycles) followed by IDLE, both dark with the prescaler restarted at each entry
    task automatic exp_off(input string tag, input int n);
        for (int j = 0; j < n; j++) push(tag, '0, 1'b0, j % C == C - 1);
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            e = sb.pop_front();
            check({e.tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
            check({e.tag, "_led"}, 32'(led), 32'(e.led));
            check({e.tag, "_tick"}, 32'(tick), 32'(e.tick));
        end
    endtask

    task automatic take(input string tag, input int p, input int n);
        g = pick(req, ptr);
        ptr = g;
        exp_show(tag, g, p, 0, n);
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        period = '0;
        #2;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_led", 32'(led), 0);
        check("rst_tick", 32'(tick), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        period[0] = 4'd1;
        req = 4'b0001;
        take("single", 1, 16);
        run(16);
        req = '0;
        exp_off("single_off", 6);
        run(6);

        period = '0;
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            take("rr", 0, 8);
            exp_off("rr_gap", 5);
            run(13);
        end

        req = 4'b0101;
        take("early", 0, 2);
        run(2);
        req = req & ~(N'(1) << g);
        exp_off("early_gap", 5);
        take("early_next", 0, 4);
        run(9);
        req = '0;
        exp_off("early_off", 6);
        run(6);

        req = 4'b0010;
        take("solid", 0, 6);
        run(6);
        period[1] = 4'd3;
        exp_show("solid_latch", g, 0, 6, 16);
        run(16);
        req = '0;
        exp_off("solid_off", 6);
        run(6);

        period[1] = 4'd2;
        req = 4'b0010;
        take("latch2", 2, 3);
        run(3);
        period[1] = 4'd0;
        exp_show("latch2_keep", g, 2, 3, 21);
        run(21);
        req = '0;
        exp_off("latch2_off", 6);
        run(6);

        req = 4'b1010;
        take("pre_rst", 0, 3);
        run(3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 0);
        check("arst_led", 32'(led), 0);
        check("arst_tick", 32'(tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = N - 1;
        take("post_rst", 0, 8);
        exp_off("post_rst_gap", 5);
        take("post_rst2", 0, 3);
        run(16);
        req = '0;
        exp_off("post_rst_off", 6);
        run(6);

        req = 4'b0110;
        for (int r = 0; r < 4; r++) begin
            take("pair", 0, 8);
            exp_off("pair_gap", 5);
            run(13);
        end
        req = '0;

        check("sb_drain", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish within 50000 time units");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares the single board status LED between `NumReq` requesters, each asking for its own blink rate. Requesters are granted one at a time (round-robin by default) for a guaranteed minimum display window, separated by a short dark gap so an observer can see ownership change. It sits between the status sources (boot, error, heartbeat, debug) and the LED pad, and supersedes the free-running blink generator at the top level.

## Interface
- `NumReq`, default 4: number of requesters; must be ≥ 2, otherwise elaboration `$error`.
- `CyclesPerTick`, default 1_000_000: clock cycles per timebase tick; must be ≥ 1, otherwise `$error`.
- `MinHoldTicks`, default 8: minimum ticks a grant is held while others wait; must be ≥ 1, otherwise `$error`.
- `PeriodWidth`, default 4: width of the per-requester half-period code.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  `NumReq`  level request, one bit per requester.
- `period_i`  in  `NumReq`×`PeriodWidth`  half-period in ticks per requester; 0 means solid on.
- `gnt_o`  out  `NumReq`  one-hot current owner; all zero when no owner.
- `led_o`  out  1  LED drive, registered.
- `tick_o`  out  1  one-cycle timebase pulse, for debug.

## Operation
- **Reset:** asynchronous.
  - `gnt_o`=0, `led_o`=0, `tick_o`=0, state IDLE.
  - RR pointer = `NumReq`-1, so requester 0 wins first.
  - Prescaler, phase and hold counters = 0.
- **Prescaler:** counts 0..`CyclesPerTick`-1 and wraps. `tick_o`=1 in the cycle the count equals `CyclesPerTick`-1. The prescaler restarts at 0 on every state change.
- **States:** IDLE, SHOW, GAP.
- **IDLE:**
  - Drives `gnt_o`=0, `led_o`=0.
  - If any `req_i` bit is set: pick a winner, go to SHOW.
  - Latch the winner's `period_i` and set the RR pointer to the winner.
- **SHOW:**
  - Drives `gnt_o`=onehot(owner). `led_o` is 1 on entry.
  - Each tick increments the phase counter. When the phase reaches latched period-1 on a tick, `led_o` toggles and phase returns to 0.
  - Latched period 0: `led_o` stays 1.
  - `period_i` changes during SHOW are ignored.
  - The hold counter increments on each tick and saturates at `MinHoldTicks`.
- **SHOW → GAP:** when the owner's `req_i` drops (immediately, regardless of hold), or when hold is saturated and any other `req_i` is set. A sole persistent requester stays in SHOW indefinitely.
- **GAP:** `gnt_o`=0, `led_o`=0. Exits to IDLE on the first tick.
- **Round-robin:** search starts at pointer+1 and wraps modulo `NumReq`.
- **Counter widths:**
  - Phase counter: `PeriodWidth` bits.
  - Hold counter: `$clog2(MinHoldTicks+1)` bits.
  - Prescaler: `$clog2(CyclesPerTick)` bits, minimum 1.
- **Simultaneous events:**
  - Owner drops in the same cycle the hold saturates: one GAP.
  - A tick and an exit condition in the same cycle: the exit wins and no LED toggle occurs.

## Timing
- A request seen in IDLE at cycle t gives `gnt_o`/`led_o` valid at t+1, which is SHOW entry t0.
- The first LED toggle is at t0+P·C, where P is the latched period and C is `CyclesPerTick`. Subsequent toggles follow every P·C cycles.
- Hold saturates at t0+`MinHoldTicks`·C.
- An exit condition at cycle e gives GAP from e+1. IDLE is entered at e+1+C.
- Minimum owner-to-owner dead time is C+1 cycles.
- Reset assertion mid-operation forces all outputs to 0 asynchronously. After deassertion, the next grant goes to the lowest-indexed active requester.

## Configuration
- **`LED_ARB_FIXED_PRIO_EN` defined:** fixed priority, lowest index wins. The RR pointer is not implemented.
- **Undefined (default):** round-robin as described above.
- All other behaviour, including hold and gap, is identical in both builds.

## Structure
- **`config_pkg`** holds:
  - `led_arb_state_e` (IDLE, SHOW, GAP).
  - The default `PeriodWidth` constant.
- **Prescaler:** a `bsg_counter_up_down` instance, reset by the state-change strobe or reset.
- **Sub-module `led_arb_rr_pick`:** combinational next-winner search, taking req vector and pointer and returning a one-hot winner and its index. Under `LED_ARB_FIXED_PRIO_EN` it reduces to a priority encoder.

## Test plan
Bench parameters: `NumReq`=4, `CyclesPerTick`=4, `MinHoldTicks`=2.
1. **Single requester:** hold `req_i`=0001 with period 1. Expect `gnt_o`=0001 one cycle later. `led_o` toggles every 4 cycles and no GAP is ever entered.
2. **Round-robin fairness:** hold `req_i`=1111 with all periods 0. Grants go 0→1→2→3→0. Each SHOW lasts 8 cycles, each GAP 4 cycles, and `led_o`=1 only during SHOW.
3. **Early drop:** grant requester 2, then drop `req_i[2]` at SHOW cycle 1. Expect GAP on the next cycle, well before hold saturates.
4. **Period 0 and latching:** requester 1 with period 0 gives `led_o` solid 1. Changing `period_i[1]` to 3 mid-SHOW causes no toggle.
5. **Async reset mid-SHOW:** assert `rst_ni`=0. All outputs go to 0 without a clock edge. After release with `req_i`=1010, expect `gnt_o`=0010.
6. **`LED_ARB_FIXED_PRIO_EN` build:** hold `req_i`=0110. Requester 1 is granted repeatedly and requester 2 is never granted.
